// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer for the 3-to-8 active-low decoder: steps a_o through 0..last_sel
// with a programmable dwell, optional blanking gap, free-run or single-step.
module decoder_scan_sequencer #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  input  logic [2:0]       last_sel,
  output logic [2:0]       a_o,
  output logic [2:0]       e_o,
  output logic             busy,
  output logic             wrap
);

  localparam int unsigned BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [2:0]  E_ON    = 3'b100;
  localparam logic [2:0]  E_OFF   = 3'b000;

  typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   cnt, cnt_nxt;
  logic [BLANK_W-1:0] bcnt, bcnt_nxt;
  logic               step_mode, step_mode_nxt;
  logic [2:0]         a_nxt, e_nxt;
  logic               busy_nxt, wrap_nxt;
  logic [2:0]         a_adv;
  logic               adv_wrap;
  logic [DIV_W-1:0]   dwell_ld;

  // Next address (>= so a lowered last_sel forces a wrap) and dwell reload (div=0 acts as 1)
  assign adv_wrap = (a_o >= last_sel);
  assign a_adv    = adv_wrap ? 3'd0 : a_o + 3'd1;
  assign dwell_ld = (div == '0) ? '0 : div - DIV_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bcnt      <= '0;
      step_mode <= 1'b0;
      a_o       <= 3'd0;
      e_o       <= E_OFF;
      busy      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bcnt      <= bcnt_nxt;
      step_mode <= step_mode_nxt;
      a_o       <= a_nxt;
      e_o       <= e_nxt;
      busy      <= busy_nxt;
      wrap      <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bcnt_nxt      = bcnt;
    step_mode_nxt = step_mode;
    a_nxt         = a_o;
    e_nxt         = e_o;
    wrap_nxt      = 1'b0;

    case (state)
      IDLE: begin
        e_nxt = E_OFF;
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt     = DWELL;
          a_nxt         = 3'd0;
          e_nxt         = E_ON;
          cnt_nxt       = dwell_ld;
          step_mode_nxt = 1'b0;
        end else if (step) begin
          state_nxt     = DWELL;
          a_nxt         = a_adv;
          wrap_nxt      = adv_wrap;
          e_nxt         = E_ON;
          cnt_nxt       = dwell_ld;
          step_mode_nxt = 1'b1;
        end
      end

      DWELL: begin
        if (stop) begin
          state_nxt     = IDLE;
          e_nxt         = E_OFF;
          step_mode_nxt = 1'b0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - DIV_W'(1);
        end else if (BLANK_CYC != 0) begin
          state_nxt = BLANK;
          e_nxt     = E_OFF;
          bcnt_nxt  = BLANK_W'(BLANK_CYC - 1);
        end else if (step_mode) begin
          state_nxt     = IDLE;
          e_nxt         = E_OFF;
          step_mode_nxt = 1'b0;
        end else begin
          // gapless free-run: stay in DWELL on the next address
          a_nxt    = a_adv;
          wrap_nxt = adv_wrap;
          cnt_nxt  = dwell_ld;
        end
      end

      BLANK: begin
        if (stop) begin
          state_nxt     = IDLE;
          e_nxt         = E_OFF;
          step_mode_nxt = 1'b0;
        end else if (bcnt != '0) begin
          bcnt_nxt = bcnt - BLANK_W'(1);
        end else if (step_mode) begin
          state_nxt     = IDLE;
          e_nxt         = E_OFF;
          step_mode_nxt = 1'b0;
        end else begin
          state_nxt = DWELL;
          a_nxt     = a_adv;
          wrap_nxt  = adv_wrap;
          e_nxt     = E_ON;
          cnt_nxt   = dwell_ld;
        end
      end

      default: begin
        state_nxt     = IDLE;
        e_nxt         = E_OFF;
        step_mode_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
